// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM states,
// stability counter width and the default qualification length.
package key_debouncer_pkg;

  localparam int CNT_W = 20;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;  // 20 ms at 50 MHz

  typedef enum logic [1:0] {
    UP,
    WAIT_DOWN,
    DOWN,
    WAIT_UP
  } key_state_t;

endpackage

// File: rtl/key_debouncer_if.sv
// Key bus between the pushbutton pins and the debouncer.
//   KEY         raw active-low pushbuttons (driven by master)
//   key_down    debounced level, 1 = pressed (driven by slave)
//   key_press   one-cycle pulse per accepted press (driven by slave)
//   key_release one-cycle pulse per accepted release (driven by slave)
interface key_debouncer_if #(
  parameter int NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output KEY,
    input  key_down,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  KEY,
    output key_down,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debouncer_ch.sv
// One debounce channel: two-flop synchronizer, UP/WAIT_DOWN/DOWN/WAIT_UP
// FSM with a stability counter, and registered level/pulse outputs.
//   CLOCK_50    system clock
//   reset       asynchronous, active-high
//   key_n       raw active-low key
//   key_down    debounced level, 1 = pressed
//   key_press   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
module key_debounce_ch
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic key_down,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             qualified;

  // The acceptance test looks at the value cnt is about to take, so a
  // stable state with LIMIT == 1 commits on the very first opposite sample
  // and the counter never exceeds LIMIT.
  always_comb begin
    cnt_next  = (state == WAIT_DOWN || state == WAIT_UP) ? cnt + CNT_W'(1) : CNT_W'(1);
    qualified = (cnt_next >= LIMIT);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      state       <= UP;
      cnt         <= '0;
      key_down    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        UP, WAIT_DOWN: begin
          if (!sync2) begin
            if (qualified) begin
              state     <= DOWN;
              cnt       <= '0;
              key_down  <= 1'b1;
              key_press <= 1'b1;
            end else begin
              state <= WAIT_DOWN;
              cnt   <= cnt_next;
            end
          end else begin
            state <= UP;
            cnt   <= '0;
          end
        end
        DOWN, WAIT_UP: begin
          if (sync2) begin
            if (qualified) begin
              state       <= UP;
              cnt         <= '0;
              key_down    <= 1'b0;
              key_release <= 1'b1;
            end else begin
              state <= WAIT_UP;
              cnt   <= cnt_next;
            end
          end else begin
            state <= DOWN;
            cnt   <= '0;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer: NUM_KEYS independent debounce channels.
//   CLOCK_50  50 MHz system clock
//   reset     asynchronous, active-high
//   bus       key bus (slave): KEY in; key_down, key_press, key_release out
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NUM_KEYS        = 4
) (
  input logic           CLOCK_50,
  input logic           reset,
  key_debouncer_if.slave bus
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .key_n      (bus.KEY[i]),
      .key_down   (bus.key_down[i]),
      .key_press  (bus.key_press[i]),
      .key_release(bus.key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
module tb_key_debouncer;

  localparam int NK   = 4;
  localparam int DC_A = 4;
  localparam int DC_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  key_debouncer_if #(.NUM_KEYS(NK)) bus_a ();
  key_debouncer_if #(.NUM_KEYS(NK)) bus_b ();

  key_debouncer #(.DEBOUNCE_CYCLES(DC_A), .NUM_KEYS(NK)) dut_a (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus_a)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DC_B), .NUM_KEYS(NK)) dut_b (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus_b)
  );

  always #10 clk = ~clk;

  // Reference model: a key flips its debounced level once the last DC
  // samples seen after synchronization all disagree with that level.
  logic [NK-1:0] raw_q [$];
  logic [NK-1:0] vis_q [$];
  logic [NK-1:0] m_down  [2];
  logic [NK-1:0] m_press [2];
  logic [NK-1:0] m_rel   [2];
  int press_cnt [NK];
  int rel_cnt   [NK];

  function automatic int dc_of(input int m);
    return (m == 0) ? DC_A : DC_B;
  endfunction

  task automatic model_reset();
    raw_q.delete();
    vis_q.delete();
    raw_q.push_back('1);
    raw_q.push_back('1);
    for (int m = 0; m < 2; m++) begin
      m_down[m]  = '0;
      m_press[m] = '0;
      m_rel[m]   = '0;
    end
  endtask

  task automatic model_edge(input logic [NK-1:0] k);
    logic [NK-1:0] v;
    bit all_opp;
    v = ~raw_q[raw_q.size()-2];
    raw_q.push_back(k);
    if (raw_q.size() > 4) void'(raw_q.pop_front());
    vis_q.push_back(v);
    if (vis_q.size() > 16) void'(vis_q.pop_front());
    for (int m = 0; m < 2; m++) begin
      m_press[m] = '0;
      m_rel[m]   = '0;
      for (int i = 0; i < NK; i++) begin
        if (vis_q.size() >= dc_of(m)) begin
          all_opp = 1'b1;
          for (int j = 0; j < dc_of(m); j++)
            if (vis_q[vis_q.size()-1-j][i] == m_down[m][i]) all_opp = 1'b0;
          if (all_opp) begin
            m_down[m][i] = ~m_down[m][i];
            if (m_down[m][i]) m_press[m][i] = 1'b1;
            else              m_rel[m][i]   = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("down_a",    bus_a.key_down,    m_down[0]);
    check("press_a",   bus_a.key_press,   m_press[0]);
    check("release_a", bus_a.key_release, m_rel[0]);
    check("excl_a",    bus_a.key_press & bus_a.key_release, '0);
    check("down_b",    bus_b.key_down,    m_down[1]);
    check("press_b",   bus_b.key_press,   m_press[1]);
    check("release_b", bus_b.key_release, m_rel[1]);
    check("excl_b",    bus_b.key_press & bus_b.key_release, '0);
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] += int'(bus_a.key_press[i]);
      rel_cnt[i]   += int'(bus_a.key_release[i]);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  task automatic step(input logic [NK-1:0] k);
    bus_a.KEY = k;
    bus_b.KEY = k;
    @(posedge clk);
    if (!rst) model_edge(k);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_down_a"},  bus_a.key_down,    '0);
    check({tag, "_press_a"}, bus_a.key_press,   '0);
    check({tag, "_rel_a"},   bus_a.key_release, '0);
    check({tag, "_down_b"},  bus_b.key_down,    '0);
  endtask

  initial begin
    logic [NK-1:0] k;
    bus_a.KEY = '1;
    bus_b.KEY = '1;
    model_reset();
    clear_counts();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Clean press on key 0, captured at edge 1
    step(4'b1110);
    step(4'b1110);
    step(4'b1110);
    check("dc1_press_e3", bus_b.key_press, 4'b0001);
    step(4'b1110);
    step(4'b1110);
    check("clean_down_e5", bus_a.key_down, 4'b0000);
    step(4'b1110);
    check("clean_press_e6", bus_a.key_press, 4'b0001);
    check("clean_down_e6",  bus_a.key_down,  4'b0001);
    step(4'b1110);
    check("clean_press_e7", bus_a.key_press, 4'b0000);

    // Long hold
    repeat (100) step(4'b1110);
    check_n("hold_press_cnt", press_cnt[0], 1);
    check_n("hold_rel_cnt",   rel_cnt[0],   0);
    check("hold_down", bus_a.key_down, 4'b0001);

    // Release
    clear_counts();
    repeat (5) step(4'b1111);
    step(4'b1111);
    check("rel_pulse_e6", bus_a.key_release, 4'b0001);
    check("rel_down_e6",  bus_a.key_down,    4'b0000);
    repeat (4) step(4'b1111);
    check_n("rel_cnt",       rel_cnt[0],   1);
    check_n("rel_press_cnt", press_cnt[0], 0);

    // Bounce on key 1
    clear_counts();
    repeat (3) step(4'b1101);
    repeat (2) step(4'b1111);
    step(4'b1101);
    repeat (4) step(4'b1101);
    step(4'b1101);
    check("bounce_press_f5", bus_a.key_press, 4'b0010);
    repeat (6) step(4'b1101);
    check_n("bounce_press_cnt", press_cnt[1], 1);
    repeat (10) step(4'b1111);

    // Simultaneous press on all keys
    repeat (5) step(4'b0000);
    step(4'b0000);
    check("simul_press", bus_a.key_press, 4'b1111);
    step(4'b0000);
    check("simul_press_next", bus_a.key_press, 4'b0000);
    check("simul_down",       bus_a.key_down,  4'b1111);
    repeat (10) step(4'b1111);

    // Reset mid-qualification
    step(4'b1110);
    step(4'b1110);
    step(4'b1110);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("rst_mid_qual");
    step(4'b1110);
    step(4'b1110);
    rst = 1'b0;
    model_reset();
    repeat (5) step(4'b1110);
    check("post_rst_down_e5", bus_a.key_down, 4'b0000);
    step(4'b1110);
    check("post_rst_press_e6", bus_a.key_press, 4'b0001);

    // Reset mid-pulse
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("rst_mid_pulse");
    step(4'b1110);
    rst = 1'b0;
    model_reset();
    repeat (8) step(4'b1110);
    repeat (10) step(4'b1111);

    // Randomized bouncing on all keys
    k = '1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) k[i] = ~k[i];
      step(k);
    end
    repeat (10) step(4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
